// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared types, widths and result reduction for the Q-learning update engine
// Contents:
//   q_state_t  : update FSM states (IDLE, SCAN, CALC, WRITE)
//   Q_EXT_BITS : guard bits added to DATA_W for the TD arithmetic (DATA_W+2)
//   Q_MAX_W    : widest DATA_W the reduction helper supports
//   q_reduce   : folds an extended result back to DATA_W bits
// Macro Q_SAT_EN: when defined q_reduce saturates, otherwise it wraps.
package q_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CALC  = 2'd2,
        WRITE = 2'd3
    } q_state_t;

    localparam int Q_EXT_BITS = 2;
    localparam int Q_MAX_W    = 64;

    // x is the extended result sign-extended to Q_MAX_W+2 bits, w is DATA_W.
    // The low w bits of the return value are the reduced Q-value; the bits
    // above w hold its sign extension.
    function automatic logic [Q_MAX_W-1:0] q_reduce(
        input logic signed [Q_MAX_W+1:0] x,
        input int                        w
    );
`ifdef Q_SAT_EN
        logic signed [Q_MAX_W+1:0] hi;
        logic signed [Q_MAX_W+1:0] lo;
        hi = ((Q_MAX_W+2)'(1) << (w - 1)) - (Q_MAX_W+2)'(1);
        lo = ~hi;
        if (x > hi) begin
            return hi[Q_MAX_W-1:0];
        end else if (x < lo) begin
            return lo[Q_MAX_W-1:0];
        end
        return x[Q_MAX_W-1:0];
`else
        logic [Q_MAX_W-1:0] r;
        // Shift the w-bit field to the top, then back down arithmetically so
        // the upper bits carry bit w-1: plain two's-complement wrap.
        r = x[Q_MAX_W-1:0] << (Q_MAX_W - w);
        r = $signed(r) >>> (Q_MAX_W - w);
        return r;
`endif
    endfunction

endpackage

// File: rtl/q_table.sv
// rtl/q_table.sv - state x action Q-value register array with scan, current, registered read and write ports
// Ports:
//   clk, rst                           : clock, asynchronous active-high clear of every entry
//   scan_state/scan_action -> scan_q   : combinational read used by the max scan
//   cur_state/cur_action   -> cur_q    : combinational read of the entry being updated
//   rd_state/rd_action     -> rd_q     : registered read (value as of the edge)
//   wr_en/wr_state/wr_action/wr_data   : synchronous write port
module q_table #(
    parameter int DATA_W  = 32,
    parameter int STATE_W = 4,
    parameter int NUM_ACT = 4,
    parameter int ACT_W   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] scan_state,
    input  logic [ACT_W-1:0]   scan_action,
    output logic [DATA_W-1:0]  scan_q,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [ACT_W-1:0]   cur_action,
    output logic [DATA_W-1:0]  cur_q,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [ACT_W-1:0]   rd_action,
    output logic [DATA_W-1:0]  rd_q,
    input  logic               wr_en,
    input  logic [STATE_W-1:0] wr_state,
    input  logic [ACT_W-1:0]   wr_action,
    input  logic [DATA_W-1:0]  wr_data
);

    localparam int ROWS = 2 ** STATE_W;
    localparam logic [ACT_W:0] ACT_MAX = (ACT_W+1)'(NUM_ACT - 1);

    logic [DATA_W-1:0] mem [ROWS][NUM_ACT];

    // Keeps indices inside the array when NUM_ACT is not a power of two.
    function automatic logic [ACT_W-1:0] clamp_act(input logic [ACT_W-1:0] a);
        return ({1'b0, a} > ACT_MAX) ? ACT_MAX[ACT_W-1:0] : a;
    endfunction

    assign scan_q = mem[scan_state][clamp_act(scan_action)];
    assign cur_q  = mem[cur_state][clamp_act(cur_action)];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int a = 0; a < NUM_ACT; a++) begin
                    mem[r][a] <= '0;
                end
            end
            rd_q <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_state][clamp_act(wr_action)] <= wr_data;
            end
            rd_q <= mem[rd_state][clamp_act(rd_action)];
        end
    end

endmodule

// File: rtl/q_update_engine.sv
// rtl/q_update_engine.sv - one temporal-difference Q-table update per accepted request
// Ports:
//   aclk, areset                          : clock, asynchronous active-high reset
//   in_valid/in_ready                     : request handshake (ready only while idle)
//   in_state, in_action, in_reward,
//   in_next, in_terminal,
//   in_alpha_sh, in_gamma_sh              : transition (s, a, r, s', terminal) and shift rates
//   out_valid, out_q, out_state,
//   out_action                            : one-cycle pulse with the written entry
//   rd_state/rd_action -> rd_q            : registered side read of the table
// Macro Q_SAT_EN: saturate the new Q-value instead of wrapping it.
module q_update_engine
    import q_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int STATE_W = 4,
    parameter int NUM_ACT = 4,
    localparam int ACT_W  = $clog2(NUM_ACT)
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [ACT_W-1:0]   in_action,
    input  logic [DATA_W-1:0]  in_reward,
    input  logic [STATE_W-1:0] in_next,
    input  logic               in_terminal,
    input  logic [4:0]         in_alpha_sh,
    input  logic [4:0]         in_gamma_sh,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_q,
    output logic [STATE_W-1:0] out_state,
    output logic [ACT_W-1:0]   out_action,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [ACT_W-1:0]   rd_action,
    output logic [DATA_W-1:0]  rd_q
);

    localparam int EW = DATA_W + Q_EXT_BITS;
    localparam logic [ACT_W:0]   ACT_MAX  = (ACT_W+1)'(NUM_ACT - 1);
    localparam logic [ACT_W-1:0] ACT_LAST = ACT_MAX[ACT_W-1:0];

    q_state_t                  state;
    logic [STATE_W-1:0]        s_reg;
    logic [STATE_W-1:0]        next_reg;
    logic [ACT_W-1:0]          a_reg;
    logic [ACT_W-1:0]          idx;
    logic                      term_reg;
    logic [4:0]                alpha_reg;
    logic [4:0]                gamma_reg;
    logic signed [DATA_W-1:0]  r_reg;
    logic signed [DATA_W-1:0]  max_reg;
    logic signed [DATA_W-1:0]  q_cur;
    logic [DATA_W-1:0]         q_new_reg;

    logic signed [DATA_W-1:0]  scan_q;
    logic [DATA_W-1:0]         cur_q;

    logic signed [EW-1:0]      m_ext;
    logic signed [EW-1:0]      td;
    logic signed [EW-1:0]      q_sum;
    logic [Q_MAX_W-1:0]        q_red;
    logic [DATA_W-1:0]         q_new;

    assign in_ready = (state == IDLE);

    q_table #(
        .DATA_W  (DATA_W),
        .STATE_W (STATE_W),
        .NUM_ACT (NUM_ACT),
        .ACT_W   (ACT_W)
    ) u_table (
        .clk         (aclk),
        .rst         (areset),
        .scan_state  (next_reg),
        .scan_action (idx),
        .scan_q      (scan_q),
        .cur_state   (s_reg),
        .cur_action  (a_reg),
        .cur_q       (cur_q),
        .rd_state    (rd_state),
        .rd_action   (rd_action),
        .rd_q        (rd_q),
        .wr_en       (state == WRITE),
        .wr_state    (s_reg),
        .wr_action   (a_reg),
        .wr_data     (q_new_reg)
    );

    // TD datapath, two guard bits so r + max - q cannot overflow before reduction.
    always_comb begin
        m_ext = '0;
        if (!term_reg) begin
            m_ext = EW'(max_reg);
        end
        td    = EW'(r_reg) + (m_ext >>> gamma_reg) - EW'(q_cur);
        q_sum = EW'(q_cur) + (td >>> alpha_reg);
        q_red = q_reduce((Q_MAX_W+2)'(q_sum), DATA_W);
        q_new = q_red[DATA_W-1:0];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= IDLE;
            s_reg      <= '0;
            next_reg   <= '0;
            a_reg      <= '0;
            idx        <= '0;
            term_reg   <= 1'b0;
            alpha_reg  <= '0;
            gamma_reg  <= '0;
            r_reg      <= '0;
            max_reg    <= '0;
            q_cur      <= '0;
            q_new_reg  <= '0;
            out_valid  <= 1'b0;
            out_q      <= '0;
            out_state  <= '0;
            out_action <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        s_reg     <= in_state;
                        a_reg     <= ({1'b0, in_action} > ACT_MAX) ? ACT_LAST : in_action;
                        r_reg     <= in_reward;
                        next_reg  <= in_next;
                        term_reg  <= in_terminal;
                        alpha_reg <= in_alpha_sh;
                        gamma_reg <= in_gamma_sh;
                        idx       <= '0;
                        max_reg   <= '0;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    // First entry seeds the max; strict > keeps the lowest index on ties.
                    if (idx == '0 || scan_q > max_reg) begin
                        max_reg <= scan_q;
                    end
                    if (idx == '0) begin
                        q_cur <= cur_q;
                    end
                    if (idx == ACT_LAST) begin
                        state <= CALC;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                CALC: begin
                    q_new_reg <= q_new;
                    state     <= WRITE;
                end
                WRITE: begin
                    out_valid  <= 1'b1;
                    out_q      <= q_new_reg;
                    out_state  <= s_reg;
                    out_action <= a_reg;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_q_update_engine.sv
// tb/tb_q_update_engine.sv - scoreboard bench for q_update_engine
module tb_q_update_engine;

    localparam int DATA_W  = 32;
    localparam int STATE_W = 4;
    localparam int NUM_ACT = 4;
    localparam int ACT_W   = 2;

    logic               aclk = 1'b0;
    logic               areset;
    logic               in_valid;
    logic               in_ready;
    logic [STATE_W-1:0] in_state;
    logic [ACT_W-1:0]   in_action;
    logic [DATA_W-1:0]  in_reward;
    logic [STATE_W-1:0] in_next;
    logic               in_terminal;
    logic [4:0]         in_alpha_sh;
    logic [4:0]         in_gamma_sh;
    logic               out_valid;
    logic [DATA_W-1:0]  out_q;
    logic [STATE_W-1:0] out_state;
    logic [ACT_W-1:0]   out_action;
    logic [STATE_W-1:0] rd_state;
    logic [ACT_W-1:0]   rd_action;
    logic [DATA_W-1:0]  rd_q;

    q_update_engine #(
        .DATA_W  (DATA_W),
        .STATE_W (STATE_W),
        .NUM_ACT (NUM_ACT)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .in_action   (in_action),
        .in_reward   (in_reward),
        .in_next     (in_next),
        .in_terminal (in_terminal),
        .in_alpha_sh (in_alpha_sh),
        .in_gamma_sh (in_gamma_sh),
        .out_valid   (out_valid),
        .out_q       (out_q),
        .out_state   (out_state),
        .out_action  (out_action),
        .rd_state    (rd_state),
        .rd_action   (rd_action),
        .rd_q        (rd_q)
    );

    always #5 aclk = ~aclk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        logic [STATE_W-1:0] st;
        logic [ACT_W-1:0]   ac;
        logic [DATA_W-1:0]  q;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mq [16][4];

    function automatic logic [DATA_W-1:0] model_q(input int s, input int a, input logic [31:0] r,
                                                  input int ns, input bit term, input int ash, input int gsh);
        longint m, q, td, qn;
        m = 0;
        if (!term) begin
            m = longint'($signed(mq[ns][0]));
            for (int i = 1; i < NUM_ACT; i++)
                if (longint'($signed(mq[ns][i])) > m) m = longint'($signed(mq[ns][i]));
        end
        q  = longint'($signed(mq[s][a]));
        td = longint'($signed(r)) + (m >>> gsh) - q;
        qn = q + (td >>> ash);
`ifdef Q_SAT_EN
        if (qn > 64'sd2147483647) qn = 64'sd2147483647;
        if (qn < -64'sd2147483648) qn = -64'sd2147483648;
`endif
        return qn[31:0];
    endfunction

    // Output monitor: every out_valid pulse must match the oldest expectation.
    always @(negedge aclk) begin
        if (!areset && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got s=%0d a=%0d q=%h, required no output",
                         out_state, out_action, out_q);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_state, out_action, out_q} !== {e.st, e.ac, e.q}) begin
                    errors++;
                    $display("FAIL out_update: got s=%0d a=%0d q=%h, required s=%0d a=%0d q=%h",
                             out_state, out_action, out_q, e.st, e.ac, e.q);
                end
            end
        end
    end

    task automatic drive_fields(input int s, input int a, input logic [31:0] r, input int ns,
                                input bit term, input int ash, input int gsh);
        in_state    = 4'(s);
        in_action   = 2'(a);
        in_reward   = r;
        in_next     = 4'(ns);
        in_terminal = term;
        in_alpha_sh = 5'(ash);
        in_gamma_sh = 5'(gsh);
    endtask

    task automatic do_req(input int s, input int a, input logic [31:0] r, input int ns, input bit term,
                          input int ash, input int gsh, input logic [31:0] exp_q, input string name);
        int   lat;
        bit   ok;
        exp_t e;
        @(posedge aclk); #1;
        drive_fields(s, a, r, ns, term, ash, gsh);
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge aclk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: in_ready stayed 0 for 40 cycles, required 1", name);
            in_valid = 1'b0;
            return;
        end
        e.st = 4'(s);
        e.ac = 2'(a);
        e.q  = exp_q;
        sb.push_back(e);
        mq[s][a] = exp_q;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge aclk);
            if (out_valid) break;
            @(posedge aclk);
            lat++;
        end
        checks++;
        if (lat !== 6) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, required 6", name, lat);
        end
    endtask

    task automatic check_rd(input int s, input int a, input logic [31:0] exp_q, input string name);
        @(posedge aclk); #1;
        rd_state  = 4'(s);
        rd_action = 2'(a);
        @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (rd_q !== exp_q) begin
            errors++;
            $display("FAIL %s: got rd_q=%h, required %h", name, rd_q, exp_q);
        end
    endtask

    task automatic test_reset();
        areset    = 1'b1;
        in_valid  = 1'b0;
        drive_fields(0, 0, 0, 0, 0, 0, 0);
        rd_state  = '0;
        rd_action = '0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_handshake: got ready=%b valid=%b, required ready=1 valid=0", in_ready, out_valid);
        end
        checks++;
        if ({out_q, out_state, out_action} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h s=%0d a=%0d, required all 0", out_q, out_state, out_action);
        end
        checks++;
        if (rd_q !== '0) begin
            errors++;
            $display("FAIL reset_rd_q: got %h, required 0", rd_q);
        end
        @(posedge aclk); #1;
        areset = 1'b0;
    endtask

    task automatic test_spec_sequence();
        do_req(2, 1, 32'd100, 3, 0, 1, 1, 32'd50, "basic");
        check_rd(2, 1, 32'd50, "basic_rd");
        do_req(1, 0, 32'd0, 2, 0, 1, 1, 32'd12, "bootstrap");
        check_rd(1, 0, 32'd12, "bootstrap_rd");
        do_req(1, 0, 32'd0, 2, 1, 1, 1, 32'd6, "terminal");
        check_rd(1, 0, 32'd6, "terminal_rd");
    endtask

    task automatic test_saturation();
        do_req(0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 32'h7FFF_FFFF, "sat_first");
`ifdef Q_SAT_EN
        do_req(0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 32'h7FFF_FFFF, "sat_second");
        check_rd(0, 0, 32'h7FFF_FFFF, "sat_rd");
`else
        do_req(0, 0, 32'h7FFF_FFFF, 0, 0, 0, 0, 32'hFFFF_FFFE, "wrap_second");
        check_rd(0, 0, 32'hFFFF_FFFE, "wrap_rd");
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            int          s, a, ns, ash, gsh;
            bit          term;
            logic [31:0] r;
            s    = $urandom_range(4, 15);
            a    = $urandom_range(0, 3);
            ns   = (i % 3 == 0) ? s : $urandom_range(4, 15);
            r    = 32'($urandom_range(0, 4000)) - 32'd2000;
            ash  = (i == 5) ? 31 : $urandom_range(0, 3);
            gsh  = (i == 6) ? 31 : $urandom_range(0, 3);
            term = (i % 4 == 3);
            do_req(s, a, r, ns, term, ash, gsh, model_q(s, a, r, ns, term, ash, gsh), "random");
        end
    endtask

    task automatic test_handshake();
        longint      last;
        int          n;
        exp_t        e;
        @(posedge aclk); #1;
        drive_fields(5, 2, 32'd1000, 5, 0, 1, 1);
        in_valid = 1'b1;
        n    = 0;
        last = 0;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(negedge aclk);
            if (in_ready) begin
                e.st = 4'd5;
                e.ac = 2'd2;
                e.q  = model_q(5, 2, 32'd1000, 5, 0, 1, 1);
                sb.push_back(e);
                mq[5][2] = e.q;
                if (n > 0) begin
                    checks++;
                    if (cyc - last !== 7) begin
                        errors++;
                        $display("FAIL held_valid_spacing: got %0d cycles, required 7", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
        end
        @(posedge aclk); #1;
        in_valid = 1'b0;
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL held_valid_accepts: got %0d, required 3", n);
        end
        repeat (10) @(posedge aclk);
        #1;
        drive_fields(3, 0, -32'sd40, 5, 0, 2, 0);
        in_valid = 1'b1;
        @(negedge aclk);
        e.st = 4'd3;
        e.ac = 2'd0;
        e.q  = model_q(3, 0, -32'sd40, 5, 0, 2, 0);
        sb.push_back(e);
        mq[3][0] = e.q;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        @(posedge aclk); #1;
        drive_fields(6, 1, 32'd77, 6, 0, 0, 0);
        in_valid = 1'b1;
        @(negedge aclk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: got in_ready=%b, required 0", in_ready);
        end
        @(posedge aclk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge aclk);
        @(negedge aclk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL pending_outputs: got %0d, required 0", sb.size());
        end
        check_rd(6, 1, 32'd0, "dropped_pulse_rd");
    endtask

    task automatic test_reset_mid();
        @(posedge aclk); #1;
        drive_fields(2, 1, 32'd500, 3, 0, 0, 0);
        in_valid = 1'b1;
        @(posedge aclk); #1;
        in_valid = 1'b0;
        @(posedge aclk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_busy: got in_ready=%b, required 0", in_ready);
        end
        areset = 1'b1;
        #1;
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL mid_reset_async: got ready=%b valid=%b, required ready=1 valid=0", in_ready, out_valid);
        end
        sb.delete();
        for (int r = 0; r < 16; r++)
            for (int a = 0; a < 4; a++)
                mq[r][a] = '0;
        @(posedge aclk); #1;
        areset = 1'b0;
        check_rd(2, 1, 32'd0, "cleared_2_1");
        check_rd(1, 0, 32'd0, "cleared_1_0");
        check_rd(0, 0, 32'd0, "cleared_0_0");
        check_rd(5, 2, 32'd0, "cleared_5_2");
    endtask

    initial begin
        for (int r = 0; r < 16; r++)
            for (int a = 0; a < 4; a++)
                mq[r][a] = '0;
        test_reset();
        test_spec_sequence();
        test_saturation();
        test_random();
        test_handshake();
        test_reset_mid();
        repeat (4) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
